rle_decompress_ctrl: RTL and testbench

Sequencer for the run-length bit decompressor. It accepts (bit value, run length) codes from the compressed-input stream and expands each run one bit per cycle into an 8-bit buffer, filled MSB-first. It emits each completed byte over a valid/ready handshake and tracks the byte and bit indices. It stops after a configured number of image bytes and raises done.

---
 rtl/rle_decompress_ctrl.sv | 134 +++++++++++++
 tb/tb_rle_decompress_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rle_decompress_ctrl.sv
// Run-length bit decompressor sequencer: expands (bit, length) codes MSB-first
// into bytes, hands them off over valid/ready and stops after IMG_BYTES bytes.
module rle_decompress_ctrl #(
  parameter int unsigned RUN_W     = 3,
  parameter int unsigned IDX_W     = 32,
  parameter int unsigned IMG_BYTES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             code_valid,
  output logic             code_ready,
  input  logic             code_bit,
  input  logic [RUN_W-1:0] code_len,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic [7:0]       byte_out,
  output logic [IDX_W-1:0] byte_indx,
  output logic [3:0]       bit_indx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXPAND,
    S_EMIT,
    S_DONE
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IMG_BYTES - 1);

  state_e           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [3:0]       bit_q, bit_d;
  logic [RUN_W-1:0] rem_q, rem_d;
  logic             run_bit_q, run_bit_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      bit_q     <= '0;
      rem_q     <= '0;
      run_bit_q <= 1'b0;
      idx_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      bit_q     <= bit_d;
      rem_q     <= rem_d;
      run_bit_q <= run_bit_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    bit_d     = bit_q;
    rem_d     = rem_q;
    run_bit_d = run_bit_q;
    idx_d     = idx_q;
    err_d     = err_q;

    case (state_q)
      S_FETCH: begin
        if (code_valid) begin
          if (code_len != '0) begin
            run_bit_d = code_bit;
            rem_d     = code_len;
            state_d   = S_EXPAND;
          end else if (bit_q != '0) begin
            state_d = S_EMIT;
          end
        end
      end
      S_EXPAND: begin
        // bit_q counts filled bits, so the next free slot is 7 - bit_q
        data_d[~bit_q[2:0]] = run_bit_q;
        bit_d = bit_q + 4'd1;
        rem_d = rem_q - RUN_W'(1);
        if (bit_q == 4'd7) begin
          state_d = S_EMIT;
        end else if (rem_q == RUN_W'(1)) begin
          state_d = S_FETCH;
        end
      end
      S_EMIT: begin
        if (byte_ready) begin
          idx_d  = (idx_q == '1) ? idx_q : idx_q + IDX_W'(1);
          data_d = '0;
          bit_d  = '0;
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            if (rem_q != '0) err_d = 1'b1;
            rem_d = '0;
          end else if (rem_q != '0) begin
            state_d = S_EXPAND;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      default: ;
    endcase

    // start overrides everything, including a handshake in the same cycle
    if (start) begin
      state_d = S_FETCH;
      data_d  = '0;
      bit_d   = '0;
      rem_d   = '0;
      idx_d   = '0;
      err_d   = 1'b0;
    end
  end

  assign code_ready = (state_q == S_FETCH);
  assign byte_valid = (state_q == S_EMIT);
  assign byte_out   = data_q;
  assign byte_indx  = idx_q;
  assign bit_indx   = bit_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_EXPAND) || (state_q == S_EMIT);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

endmodule

// File: tb/tb_rle_decompress_ctrl.sv
// Bench for rle_decompress_ctrl: table vectors, directed corner sequences and
// randomized images checked against a bit-stream model.
module tb_rle_decompress_ctrl;

  localparam int unsigned IMG = 16;

  logic        clk = 1'b0;
  logic        rst, start, code_valid, code_bit, byte_ready;
  logic [2:0]  code_len;
  logic        code_ready, byte_valid, busy, done, err;
  logic [7:0]  byte_out;
  logic [31:0] byte_indx;
  logic [3:0]  bit_indx;
  logic        code_ready2, byte_valid2, busy2, done2, err2;
  logic [7:0]  byte_out2;
  logic [31:0] byte_indx2;
  logic [3:0]  bit_indx2;

  rle_decompress_ctrl #(.RUN_W(3), .IDX_W(32), .IMG_BYTES(IMG)) dut (
    .clk(clk), .rst(rst), .start(start), .code_valid(code_valid),
    .code_ready(code_ready), .code_bit(code_bit), .code_len(code_len),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_out(byte_out),
    .byte_indx(byte_indx), .bit_indx(bit_indx), .busy(busy), .done(done), .err(err)
  );

  // Short-image instance shares all inputs; used for the image-end sequence.
  rle_decompress_ctrl #(.RUN_W(3), .IDX_W(32), .IMG_BYTES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .code_valid(code_valid),
    .code_ready(code_ready2), .code_bit(code_bit), .code_len(code_len),
    .byte_valid(byte_valid2), .byte_ready(byte_ready), .byte_out(byte_out2),
    .byte_indx(byte_indx2), .bit_indx(bit_indx2), .busy(busy2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0, n_bad = 0;
  int unsigned cyc = 0, code_acc = 0, exp_cycles = 0;
  logic [7:0]  q[$];
  logic [7:0]  q2[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change at posedge+1, so values seen here are what the next edge uses.
  always @(negedge clk) begin
    if (!rst && !start) begin
      if (byte_valid && byte_ready) q.push_back(byte_out);
      if (byte_valid2 && byte_ready) q2.push_back(byte_out2);
      if (code_valid && code_ready) code_acc++;
      if (busy && !code_ready && !byte_valid) exp_cycles++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout, expected event", nm);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    q.delete(); q2.delete();
    code_acc = 0;
    exp_cycles = 0;
  endtask

  task automatic send_code(input logic b, input logic [2:0] len);
    int unsigned t = 0;
    code_bit = b;
    code_len = len;
    code_valid = 1'b1;
    @(negedge clk);
    while (!code_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!code_ready) tmo("code_accept");
    @(posedge clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int unsigned n, input string nm);
    int unsigned t = 0;
    while (q.size() < n && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (q.size() < n) tmo(nm);
  endtask

  typedef struct packed {
    logic [2:0]  n;
    logic [19:0] codes;   // up to five {bit, len[2:0]} codes, first code in [19:16]
    logic [7:0]  exp;
  } vec_t;

  vec_t        tbl[8];
  logic [19:0] cw;
  logic [3:0]  c;
  int unsigned nlen, t, acc0, c0, nb, l;
  logic [7:0]  acc;
  logic        b, exp_err, img_done;
  logic [3:0]  codes_q[$];
  logic [7:0]  exp_q[$];

  initial begin
    tbl[0] = '{3'd5, 20'h192B1, 8'h4E};
    tbl[1] = '{3'd2, 20'hB0000, 8'hE0};
    tbl[2] = '{3'd2, 20'hF1000, 8'hFE};
    tbl[3] = '{3'd2, 20'h4C000, 8'h0F};
    tbl[4] = '{3'd2, 20'h90000, 8'h80};
    tbl[5] = '{3'd4, 20'hA2A20, 8'hCC};
    tbl[6] = '{3'd2, 20'h79000, 8'h01};
    tbl[7] = '{3'd2, 20'hD3000, 8'hF8};

    rst = 1'b1; start = 1'b0; code_valid = 1'b0; code_bit = 1'b0;
    code_len = 3'd0; byte_ready = 1'b1;
    @(posedge clk); #1;
    chk("reset_flags", {31'd0, code_ready, byte_valid, busy, done, err}, 32'd0);
    chk("reset_byte_out", byte_out, 8'h00);
    chk("reset_byte_indx", byte_indx, 32'd0);
    chk("reset_bit_indx", bit_indx, 4'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_code_ready", code_ready, 1'b0);

    // Single-byte vectors
    for (int i = 0; i < 8; i++) begin
      byte_ready = 1'b1;
      do_start();
      nlen = 0;
      cw = tbl[i].codes;
      for (int j = 0; j < int'(tbl[i].n); j++) begin
        c = cw[19-4*j -: 4];
        nlen += int'(c[2:0]);
        send_code(c[3], c[2:0]);
      end
      wait_bytes(1, $sformatf("vec%0d_wait", i));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_byte", i), (q.size() > 0) ? q[0] : 8'h00, tbl[i].exp);
      chk($sformatf("vec%0d_byte_indx", i), byte_indx, 32'd1);
      chk($sformatf("vec%0d_bit_indx", i), bit_indx, 4'd0);
      chk($sformatf("vec%0d_code_ready", i), code_ready, 1'b1);
      chk($sformatf("vec%0d_expand_cycles", i), exp_cycles, nlen);
    end

    // Run continuing across a byte boundary
    do_start();
    send_code(1'b1, 3'd7);
    send_code(1'b1, 3'd3);
    wait_bytes(1, "cross_wait1");
    @(posedge clk); #1;
    chk("cross_no_fetch", code_ready, 1'b0);
    chk("cross_mid_busy", busy, 1'b1);
    chk("cross_mid_byte_indx", byte_indx, 32'd1);
    send_code(1'b0, 3'd6);
    wait_bytes(2, "cross_wait2");
    @(posedge clk); #1;
    chk("cross_byte0", (q.size() > 0) ? q[0] : 8'h00, 8'hFF);
    chk("cross_byte1", (q.size() > 1) ? q[1] : 8'h00, 8'hC0);
    chk("cross_byte_indx", byte_indx, 32'd2);
    chk("cross_expand_cycles", exp_cycles, 32'd16);
    chk("cross_codes", code_acc, 32'd3);

    // Backpressure at the first EMIT
    do_start();
    byte_ready = 1'b0;
    send_code(1'b0, 3'd1); send_code(1'b1, 3'd1); send_code(1'b0, 3'd2);
    send_code(1'b1, 3'd3); send_code(1'b0, 3'd1);
    t = 0;
    while (!byte_valid && t < 50) begin @(posedge clk); #1; t++; end
    if (!byte_valid) tmo("bp_valid");
    code_valid = 1'b1; code_bit = 1'b1; code_len = 3'd2;
    acc0 = code_acc;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_%0d", i), byte_valid, 1'b1);
      chk($sformatf("bp_byte_%0d", i), byte_out, 8'h4E);
      chk($sformatf("bp_code_ready_%0d", i), code_ready, 1'b0);
      @(posedge clk); #1;
    end
    byte_ready = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0;
    chk("bp_code_stall", code_acc, acc0);
    chk("bp_handshakes", q.size(), 32'd1);
    chk("bp_byte_indx", byte_indx, 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    chk("bp_byte_indx_hold", byte_indx, 32'd1);

    // Flush with partial byte, then flush with empty byte
    do_start();
    send_code(1'b1, 3'd3);
    send_code(1'b0, 3'd0);
    wait_bytes(1, "flush_wait");
    @(posedge clk); #1;
    chk("flush_byte", (q.size() > 0) ? q[0] : 8'h00, 8'hE0);
    chk("flush_bit_indx", bit_indx, 4'd0);
    c0 = cyc;
    send_code(1'b0, 3'd0);
    chk("flush_empty_cycles", cyc - c0, 32'd1);
    chk("flush_empty_fetch", code_ready, 1'b1);
    repeat (4) begin @(posedge clk); #1; end
    chk("flush_empty_nobyte", q.size(), 32'd1);
    chk("flush_byte_indx", byte_indx, 32'd1);

    // Image end on the two-byte instance
    do_start();
    send_code(1'b1, 3'd7); send_code(1'b1, 3'd7); send_code(1'b1, 3'd7);
    t = 0;
    while (!done2 && t < 100) begin @(posedge clk); #1; t++; end
    if (!done2) tmo("end_done");
    chk("end_bytes", q2.size(), 32'd2);
    chk("end_byte0", (q2.size() > 0) ? q2[0] : 8'h00, 8'hFF);
    chk("end_byte1", (q2.size() > 1) ? q2[1] : 8'h00, 8'hFF);
    chk("end_err", err2, 1'b1);
    chk("end_outs", {29'd0, code_ready2, byte_valid2, busy2}, 32'd0);
    chk("end_byte_indx", byte_indx2, 32'd2);
    do_start();
    chk("end_restart_flags", {30'd0, done2, err2}, 32'd0);
    chk("end_restart_byte_indx", byte_indx2, 32'd0);
    chk("end_restart_fetch", code_ready2, 1'b1);

    // Asynchronous reset mid-EXPAND
    do_start();
    send_code(1'b1, 3'd7);
    @(posedge clk); #1;
    chk("rst_pre_busy", busy, 1'b1);
    rst = 1'b1;
    #2;
    chk("rst_async_flags", {31'd0, code_ready, byte_valid, busy, done, err}, 32'd0);
    chk("rst_async_byte_out", byte_out, 8'h00);
    chk("rst_async_bit_indx", bit_indx, 4'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // start abort mid-EXPAND at bit_indx 5
    do_start();
    send_code(1'b1, 3'd7);
    t = 0;
    while (bit_indx != 4'd5 && t < 20) begin @(posedge clk); #1; t++; end
    if (bit_indx != 4'd5) tmo("abort_reach5");
    do_start();
    chk("abort_bit_indx", bit_indx, 4'd0);
    chk("abort_fetch", code_ready, 1'b1);
    repeat (12) begin @(posedge clk); #1; end
    chk("abort_nobyte", q.size(), 32'd0);
    chk("abort_byte_indx", byte_indx, 32'd0);
    chk("abort_still_fetch", code_ready, 1'b1);

    // Random images against the bit-stream model
    for (int img = 0; img < 5; img++) begin
      codes_q.delete(); exp_q.delete();
      nb = 0; acc = 8'h00; exp_err = 1'b0; img_done = 1'b0;
      while (!img_done) begin
        b = 1'($urandom_range(0, 1));
        l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
        codes_q.push_back({b, l[2:0]});
        if (l == 0) begin
          if (nb > 0) begin
            exp_q.push_back(8'(acc << (8 - nb)));
            acc = 8'h00; nb = 0;
          end
        end else begin
          for (int unsigned k = 0; k < l; k++) begin
            acc = {acc[6:0], b};
            nb++;
            if (nb == 8) begin
              exp_q.push_back(acc);
              acc = 8'h00; nb = 0;
              if (exp_q.size() == IMG) begin
                exp_err = (k != l - 1);
                break;
              end
            end
          end
        end
        if (exp_q.size() == IMG) img_done = 1'b1;
      end

      byte_ready = 1'b1;
      do_start();
      fork
        begin
          foreach (codes_q[i]) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_code(codes_q[i][3], codes_q[i][2:0]);
          end
        end
        begin
          int unsigned tt = 0;
          while (!done && tt < 4000) begin
            byte_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            tt++;
          end
          byte_ready = 1'b1;
        end
      join
      chk($sformatf("rnd%0d_done", img), done, 1'b1);
      chk($sformatf("rnd%0d_err", img), err, exp_err);
      chk($sformatf("rnd%0d_byte_indx", img), byte_indx, IMG);
      chk($sformatf("rnd%0d_codes", img), code_acc, codes_q.size());
      chk($sformatf("rnd%0d_nbytes", img), q.size(), exp_q.size());
      foreach (exp_q[i]) begin
        chk($sformatf("rnd%0d_byte%0d", img, i), (i < q.size()) ? q[i] : 8'hxx, exp_q[i]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
